bitmap_scan_encoder: RTL
========================

BITMAP_SCAN_ENCODER -- requirements
Module: bitmap_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the input bitmap width; legal values are powers of two, 2..1024.
REQ-002 SHALL have localparam IDXW, equal to log2(WIDTH), giving the index width (5 at default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of the current vector.
REQ-006 SHALL have port in_valid, input, 1 bit: the bitmap is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a bitmap.
REQ-008 SHALL have port in_vec, input, WIDTH bits: the bitmap to scan.
REQ-009 SHALL have port in_msb_first, input, 1 bit: scan order, 0 = LSB-first and 1 = MSB-first; latched on accept.
REQ-010 SHALL have port out_valid, output, 1 bit: the index beat is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port out_idx, output, IDXW bits: bit position of the current set bit.
REQ-013 SHALL have port out_seq, output, IDXW+1 bits: zero-based beat number within the current vector.
REQ-014 SHALL have port out_last, output, 1 bit: this is the final beat of the current vector.
REQ-015 SHALL have port out_zero, output, 1 bit: the accepted vector had no set bits.

Function
REQ-016 SHALL implement states IDLE, SCAN and ZERO, with in_ready = (state==IDLE) and out_valid = (state!=IDLE).
REQ-017 SHALL, in IDLE on in_valid&in_ready, register in_vec into mask, latch in_msb_first, clear out_seq, and enter SCAN if in_vec!=0, else ZERO.
REQ-018 SHALL assert out_valid first in the cycle after accept, giving 1-cycle latency.
REQ-019 SHALL, in SCAN, drive out_idx as the lowest set bit of mask when LSB-first, or the highest set bit when MSB-first.
REQ-020 SHALL, in SCAN, drive out_last=1 when mask has exactly one bit set, and out_zero=0.
REQ-021 SHALL, in SCAN on out_valid&out_ready, clear bit out_idx in mask and increment out_seq; if out_last, enter IDLE.
REQ-022 SHALL, in ZERO, drive out_idx=0, out_seq=0, out_last=1 and out_zero=1, and enter IDLE on out_ready.
REQ-023 SHALL hold out_idx, out_seq, out_last and out_zero stable while out_valid&!out_ready.
REQ-024 SHALL emit exactly popcount(in_vec) beats for a nonzero vector, or 1 beat for a zero vector, with no gaps while out_ready=1.
REQ-025 SHALL have a 1-cycle bubble between vectors (in_ready is low on the last output handshake cycle).
REQ-026 SHALL, on flush=1 in any state, enter IDLE and clear mask and out_seq, discarding any pending beat; flush takes priority over a simultaneous accept or handshake.
REQ-027 SHALL, when mask has bit WIDTH-1 set (MSB-first) or bit 0 set (LSB-first), emit that boundary index first; index wrap-around is never required.
REQ-028 SHALL never overflow out_seq, since its maximum value is WIDTH-1.

Reset
REQ-029 SHALL, while rst=1, asynchronously force state=IDLE, mask=0, out_seq=0, latched order=0 and, if enabled, out_total=0.
REQ-030 SHALL, during and after reset, drive out_valid=0, in_ready=1, out_idx=0, out_last=0 and out_zero=0.
REQ-031 SHALL, on reset asserted mid-vector, drop the vector with no further beats after deassertion.

Configuration
REQ-032 SHALL, with macro BITMAP_SCAN_POPCOUNT_EN defined, add output out_total [IDXW:0] holding popcount(in_vec), registered at accept and constant for the vector (0 for a zero vector).
REQ-033 SHALL, without BITMAP_SCAN_POPCOUNT_EN, omit out_total and its adder tree, leaving all other behaviour identical.

Verification
REQ-034 SHALL cover: WIDTH=32, in_vec=0x8000_0011, LSB-first, out_ready=1 -> idx 0,4,31 on consecutive cycles; seq 0,1,2; last on idx 31.
REQ-035 SHALL cover: the same vector MSB-first -> idx 31,4,0, with out_last on idx 0; out_total=3 when enabled.
REQ-036 SHALL cover: in_vec=0 -> one beat with out_zero=1, out_last=1, idx=0, then in_ready=1 the following cycle.
REQ-037 SHALL cover: in_vec=0xFFFF_FFFF with out_ready toggled 1/0 -> 32 beats idx 0..31 in order, outputs stable on stall cycles.
REQ-038 SHALL cover: flush asserted on beat 2 of 0x0000_00FF -> next cycle out_valid=0 and in_ready=1, and the next vector 0x2 yields a single beat idx 1 with seq 0.
REQ-039 SHALL cover: rst pulsed mid-scan of 0x0F0 -> out_valid=0 immediately, and no residual beats after release.

Source files
------------

// File: rtl/bitmap_scan_encoder.sv
// Streams the set-bit positions of an accepted bitmap, one index per beat, LSB- or MSB-first.
// Optional out_total popcount port is enabled by defining BITMAP_SCAN_POPCOUNT_EN.
module bitmap_scan_encoder #(
   parameter  int WIDTH = 32,
   localparam int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             in_msb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic [IDXW:0]    out_seq,
   output logic             out_last,
   output logic             out_zero
`ifdef BITMAP_SCAN_POPCOUNT_EN
   ,
   output logic [IDXW:0]    out_total
`endif
);
   typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_mask,  w_mask_nxt;
   logic [IDXW:0]    r_seq,   w_seq_nxt;
   logic             r_msb,   w_msb_nxt;
   logic [IDXW-1:0]  w_lo_idx, w_hi_idx;
   logic             w_one_left, w_accept, w_beat;

   // Priority encoders: the last match in each loop wins
   always_comb begin
      w_lo_idx = '0;
      w_hi_idx = '0;
      for (int i = WIDTH-1; i >= 0; i--)
         if (r_mask[i]) w_lo_idx = IDXW'(i);
      for (int i = 0; i < WIDTH; i++)
         if (r_mask[i]) w_hi_idx = IDXW'(i);
   end

   assign w_one_left = (r_mask != '0) && ((r_mask & (r_mask - WIDTH'(1))) == '0);

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state != IDLE);
   assign out_idx   = (r_state == SCAN) ? (r_msb ? w_hi_idx : w_lo_idx) : '0;
   assign out_seq   = r_seq;
   assign out_last  = (r_state == ZERO) || ((r_state == SCAN) && w_one_left);
   assign out_zero  = (r_state == ZERO);
   assign w_accept  = in_valid & in_ready;
   assign w_beat    = out_valid & out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_seq_nxt   = r_seq;
      w_msb_nxt   = r_msb;
      if (flush) begin
         w_state_nxt = IDLE;
         w_mask_nxt  = '0;
         w_seq_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               w_mask_nxt  = in_vec;
               w_msb_nxt   = in_msb_first;
               w_seq_nxt   = '0;
               w_state_nxt = (in_vec != '0) ? SCAN : ZERO;
            end
            SCAN: if (w_beat) begin
               w_mask_nxt[out_idx] = 1'b0;
               w_seq_nxt           = r_seq + (IDXW+1)'(1);
               if (out_last) w_state_nxt = IDLE;
            end
            ZERO: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_seq   <= '0;
         r_msb   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_seq   <= w_seq_nxt;
         r_msb   <= w_msb_nxt;
      end
   end

`ifdef BITMAP_SCAN_POPCOUNT_EN
   logic [IDXW:0] r_total, w_pop;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WIDTH; i++)
         w_pop = w_pop + (IDXW+1)'(in_vec[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_total <= '0;
      else if (w_accept && !flush) r_total <= w_pop;
   end

   assign out_total = r_total;
`endif

endmodule
